adc_frame_queue_to_fifo: RTL and testbench

//  Next-gen ADC frame push sequencer. Queues up to FRAME_DEPTH packed frames in

---
 rtl/adc_frame_queue_to_fifo.sv | 178 +++++++++++++++++
 tb/tb_adc_frame_queue_to_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_queue_to_fifo.sv
// ADC frame push sequencer: queues packed frames in circular slots and serialises them to a ready/valid FIFO port.
// Define ADC_FRAME_HDR_EN to prefix each frame with a {8'hA5, seq, WORDS_OUT} header beat.
module adc_frame_queue_to_fifo #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WORDS_IN    = 10,
  parameter int unsigned WORDS_OUT   = 9,
  parameter int unsigned FRAME_DEPTH = 2,
  localparam int unsigned CNT_W      = $clog2(FRAME_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_enable,
  input  logic                       flush,
  input  logic                       clr_overrun,
  input  logic                       frame_valid,
  input  logic [DATA_W*WORDS_IN-1:0] frame_words_packed,
  output logic                       push_valid,
  output logic [DATA_W-1:0]          push_data,
  input  logic                       push_ready,
  output logic                       busy,
  output logic [CNT_W-1:0]           frames_queued,
  output logic                       frame_dropped,
  output logic [15:0]                drop_count,
  output logic                       overrun
);

`ifdef ADC_FRAME_HDR_EN
  localparam int unsigned LEN = WORDS_OUT + 1;
`else
  localparam int unsigned LEN = WORDS_OUT;
`endif
  localparam int unsigned IDX_W  = $clog2(LEN + 1);
  localparam int unsigned PTR_W  = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
  localparam int unsigned WIDX_W = (WORDS_OUT > 1) ? $clog2(WORDS_OUT) : 1;
  localparam int unsigned SLOT_W = DATA_W * WORDS_OUT;

  logic [SLOT_W-1:0] slot_mem [FRAME_DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, nxt_wr, nxt_rd;
  logic [IDX_W-1:0]  idx, nxt_idx;
  logic [CNT_W-1:0]  nxt_count;
  logic [15:0]       nxt_drop_count;
  logic              nxt_overrun;
  logic [DATA_W-1:0] nxt_data;
  logic [WIDX_W-1:0] widx;
  logic              hs, last_beat, slot_free, accept, drop, fwd;

`ifdef ADC_FRAME_HDR_EN
  logic [7:0] seq_cnt;
  logic [7:0] slot_seq [FRAME_DEPTH];
  logic [7:0] hdr_seq;
`endif

  // Words above WORDS_OUT (e.g. CRC) are intentionally discarded.
  generate
    if (WORDS_IN > WORDS_OUT) begin : g_unused
      logic unused_upper_words;
      assign unused_upper_words = ^frame_words_packed[DATA_W*WORDS_IN-1:SLOT_W];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FRAME_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: queue bookkeeping, drop accounting and the next presented word.
  always_comb begin
    hs             = push_valid && push_ready;
    last_beat      = hs && (idx == IDX_W'(LEN - 1));
    slot_free      = (frames_queued < CNT_W'(FRAME_DEPTH)) || last_beat;
    accept         = frame_valid && cfg_enable && slot_free && !flush;
    drop           = frame_valid && cfg_enable && !slot_free && !flush;
    nxt_wr         = wr_ptr;
    nxt_rd         = rd_ptr;
    nxt_idx        = idx;
    nxt_count      = frames_queued;
    nxt_drop_count = drop_count;
    nxt_overrun    = overrun;
    nxt_data       = '0;
    widx           = '0;
    fwd            = 1'b0;
`ifdef ADC_FRAME_HDR_EN
    hdr_seq        = '0;
`endif

    if (flush) begin
      nxt_wr    = '0;
      nxt_rd    = '0;
      nxt_idx   = '0;
      nxt_count = '0;
    end else begin
      if (hs) begin
        if (last_beat) begin
          nxt_idx = '0;
          nxt_rd  = ptr_inc(rd_ptr);
        end else begin
          nxt_idx = idx + IDX_W'(1);
        end
      end
      if (accept) nxt_wr = ptr_inc(wr_ptr);
      case ({accept, last_beat})
        2'b10:   nxt_count = frames_queued + CNT_W'(1);
        2'b01:   nxt_count = frames_queued - CNT_W'(1);
        default: nxt_count = frames_queued;
      endcase
    end

    if (drop) begin
      nxt_overrun    = 1'b1;
      nxt_drop_count = clr_overrun ? 16'd1 :
                       (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
    end else if (clr_overrun) begin
      nxt_overrun    = 1'b0;
      nxt_drop_count = '0;
    end

    // A frame written this cycle into the slot about to be read is forwarded from the input.
    fwd = accept && (wr_ptr == nxt_rd);
`ifdef ADC_FRAME_HDR_EN
    widx = WIDX_W'(nxt_idx - IDX_W'(1));
    if (nxt_idx == '0) begin
      hdr_seq  = fwd ? seq_cnt : slot_seq[nxt_rd];
      nxt_data = DATA_W'({8'hA5, hdr_seq, 16'(WORDS_OUT)});
    end else begin
      nxt_data = fwd ? frame_words_packed[DATA_W*widx +: DATA_W]
                     : slot_mem[nxt_rd][DATA_W*widx +: DATA_W];
    end
`else
    widx     = WIDX_W'(nxt_idx);
    nxt_data = fwd ? frame_words_packed[DATA_W*widx +: DATA_W]
                   : slot_mem[nxt_rd][DATA_W*widx +: DATA_W];
`endif
    if (nxt_count == '0) nxt_data = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      idx           <= '0;
      frames_queued <= '0;
      push_valid    <= 1'b0;
      push_data     <= '0;
      busy          <= 1'b0;
      frame_dropped <= 1'b0;
      drop_count    <= '0;
      overrun       <= 1'b0;
    end else begin
      wr_ptr        <= nxt_wr;
      rd_ptr        <= nxt_rd;
      idx           <= nxt_idx;
      frames_queued <= nxt_count;
      push_valid    <= (nxt_count != '0);
      push_data     <= nxt_data;
      busy          <= (nxt_count != '0);
      frame_dropped <= drop;
      drop_count    <= nxt_drop_count;
      overrun       <= nxt_overrun;
    end
  end

  // Slot payload storage; contents are only observed once a slot is occupied.
  always_ff @(posedge clk) begin
    if (accept) slot_mem[wr_ptr] <= frame_words_packed[SLOT_W-1:0];
  end

`ifdef ADC_FRAME_HDR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      seq_cnt <= '0;
    else if (accept) seq_cnt <= seq_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (accept) slot_seq[wr_ptr] <= seq_cnt;
  end
`endif

endmodule

// File: tb/tb_adc_frame_queue_to_fifo.sv
// Bench for adc_frame_queue_to_fifo: frame-queue reference model plus directed literal checks.
module tb_adc_frame_queue_to_fifo;
  localparam int DATA_W = 32;
  localparam int WORDS_IN = 10;
  localparam int WORDS_OUT = 9;
  localparam int DEPTH = 2;
`ifdef ADC_FRAME_HDR_EN
  localparam int LEN = WORDS_OUT + 1;
`else
  localparam int LEN = WORDS_OUT;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_enable = 1'b1;
  logic flush = 1'b0;
  logic clr_overrun = 1'b0;
  logic frame_valid = 1'b0;
  logic [DATA_W*WORDS_IN-1:0] frame_words_packed = '0;
  logic push_valid;
  logic [DATA_W-1:0] push_data;
  logic push_ready = 1'b0;
  logic busy;
  logic [1:0] frames_queued;
  logic frame_dropped;
  logic [15:0] drop_count;
  logic overrun;

  adc_frame_queue_to_fifo dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .flush(flush),
    .clr_overrun(clr_overrun), .frame_valid(frame_valid),
    .frame_words_packed(frame_words_packed), .push_valid(push_valid),
    .push_data(push_data), .push_ready(push_ready), .busy(busy),
    .frames_queued(frames_queued), .frame_dropped(frame_dropped),
    .drop_count(drop_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: flat queue of expected beats plus frame count and position in the oldest frame.
  logic [31:0] exp_q[$];
  logic [31:0] act_log[$];
  int m_cnt = 0;
  int m_pos = 0;
  int m_dc = 0;
  logic m_ovr = 1'b0;
  logic m_drop = 1'b0;
`ifdef ADC_FRAME_HDR_EN
  logic [7:0] m_seq = 8'd0;
`endif

  always @(posedge clk or negedge rst_n) begin : model
    bit hs, lb, fr;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0; m_pos = 0; m_dc = 0; m_ovr = 1'b0; m_drop = 1'b0;
`ifdef ADC_FRAME_HDR_EN
      m_seq = 8'd0;
`endif
    end else begin
      if (push_valid && push_ready) act_log.push_back(push_data);
      hs = (m_cnt != 0) && push_ready;
      lb = hs && (m_pos == LEN - 1);
      fr = (m_cnt < DEPTH) || lb;
      m_drop = 1'b0;
      if (flush) begin
        exp_q.delete();
        m_cnt = 0;
        m_pos = 0;
      end else begin
        if (hs) begin
          void'(exp_q.pop_front());
          if (lb) begin m_pos = 0; m_cnt--; end
          else m_pos++;
        end
        if (frame_valid && cfg_enable) begin
          if (fr) begin
`ifdef ADC_FRAME_HDR_EN
            exp_q.push_back(32'hA500_0000 | (32'(m_seq) << 16) | 32'(WORDS_OUT));
            m_seq++;
`endif
            for (int k = 0; k < WORDS_OUT; k++) exp_q.push_back(frame_words_packed[32*k +: 32]);
            m_cnt++;
          end else begin
            m_drop = 1'b1;
          end
        end
      end
      if (m_drop) begin
        m_ovr = 1'b1;
        m_dc = clr_overrun ? 1 : ((m_dc == 16'hFFFF) ? m_dc : m_dc + 1);
      end else if (clr_overrun) begin
        m_ovr = 1'b0;
        m_dc = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    chk("push_valid", 32'(push_valid), 32'(m_cnt != 0));
    if (m_cnt != 0 && exp_q.size() > 0) chk("push_data", push_data, exp_q[0]);
    chk("frames_queued", 32'(frames_queued), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("frame_dropped", 32'(frame_dropped), 32'(m_drop));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  end

  task automatic load_frame(input logic [31:0] base, input bit rnd);
    for (int k = 0; k < WORDS_IN; k++)
      frame_words_packed[32*k +: 32] = rnd ? $urandom : base + 32'(k);
    frame_valid = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] base);
    load_frame(base, 1'b0);
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] lit[$];
    repeat (3) @(negedge clk);
    chk("rst_push_valid", 32'(push_valid), 32'd0);
    chk("rst_push_data", push_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames_queued", 32'(frames_queued), 32'd0);
    chk("rst_frame_dropped", 32'(frame_dropped), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two frames drained at full rate; upper CRC word must never appear.
    push_ready = 1'b1;
    send_frame(32'h100);
    wait_idle(100);
    send_frame(32'h200);
    wait_idle(100);
    for (int f = 0; f < 2; f++) begin
`ifdef ADC_FRAME_HDR_EN
      lit.push_back(32'hA500_0009 + (32'(f) << 16));
`endif
      for (int k = 0; k < 9; k++) lit.push_back(32'h100 * 32'(f + 1) + 32'(k));
    end
    chk("lit_beat_count", 32'(act_log.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size() && i < act_log.size(); i++) chk("lit_beat", act_log[i], lit[i]);
    chk("lit_busy_after", 32'(busy), 32'd0);

    // Stalled FIFO: third back-to-back frame is dropped.
    push_ready = 1'b0;
    load_frame(32'h300, 1'b0); @(negedge clk);
    load_frame(32'h400, 1'b0); @(negedge clk);
    load_frame(32'h500, 1'b0); @(negedge clk);
    frame_valid = 1'b0;
    chk("lit_drop_pulse", 32'(frame_dropped), 32'd1);
    chk("lit_drop_count", 32'(drop_count), 32'd1);
    chk("lit_overrun", 32'(overrun), 32'd1);
    chk("lit_queued_full", 32'(frames_queued), 32'd2);

    // Full queue: new frame lands in the same cycle as the last-word handoff.
    push_ready = 1'b1;
    repeat (LEN - 1) @(negedge clk);
    send_frame(32'h600);
    chk("lit_reuse_queued", 32'(frames_queued), 32'd2);
    chk("lit_reuse_no_drop", 32'(frame_dropped), 32'd0);
    chk("lit_reuse_count", 32'(drop_count), 32'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("lit_clr_overrun", 32'(overrun), 32'd0);
    chk("lit_clr_count", 32'(drop_count), 32'd0);
    wait_idle(100);

    // Flush mid-frame with a second frame queued and a frame strobe in the flush cycle.
    send_frame(32'h700);
    send_frame(32'h800);
    repeat (2) @(negedge clk);
    load_frame(32'h900, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    frame_valid = 1'b0;
    chk("lit_flush_valid", 32'(push_valid), 32'd0);
    chk("lit_flush_queued", 32'(frames_queued), 32'd0);
    push_ready = 1'b0;
    send_frame(32'hA00);
    chk("lit_restart_valid", 32'(push_valid), 32'd1);
`ifdef ADC_FRAME_HDR_EN
    chk("lit_restart_word0", push_data, 32'hA507_0009);
`else
    chk("lit_restart_word0", push_data, 32'hA00);
`endif
    push_ready = 1'b1;
    wait_idle(100);

    // 20 random frames spaced 15 cycles with a 50% ready FIFO.
    for (int i = 0; i < 20; i++) begin
      load_frame(0, 1'b1);
      push_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      frame_valid = 1'b0;
      repeat (14) begin
        push_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end

    // Mixed random traffic including flush, clear and enable toggling.
    for (int c = 0; c < 1500; c++) begin
      push_ready  = 1'($urandom_range(0, 1));
      cfg_enable  = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 49) == 0);
      clr_overrun = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) < 4) load_frame(0, 1'b1);
      else frame_valid = 1'b0;
      @(negedge clk);
    end
    frame_valid = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
    cfg_enable = 1'b1; push_ready = 1'b1;
    wait_idle(100);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
